aes_key_unroll_128: RTL and testbench



---
 rtl/aes_key_unroll_128_if.sv | 33 +++
 rtl/aes_key_unroll_128.sv | 149 ++++++++++++++
 tb/tb_aes_key_unroll_128.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_key_unroll_128_if.sv
// aes_key_unroll_128_if
//   Bundles the load handshake and the round-key output stream of the AES-128
//   inverse key scheduler.
//   master : drives start/key_in/out_ready and observes the key stream.
//   slave  : the scheduler itself.
//   start     - load key_in and begin the walk (ignored while busy)
//   key_in    - round-10 key {w40,w41,w42,w43}
//   key_out   - current round key, same word order
//   round_idx - round number of key_out (10..0)
//   key_valid - key_out/round_idx valid
//   out_ready - consumer accepts the current key
//   busy      - walk in progress
//   done      - one-cycle pulse after round 0 is accepted
interface aes_key_unroll_128_if;
  logic         start;
  logic [127:0] key_in;
  logic         out_ready;
  logic [127:0] key_out;
  logic [3:0]   round_idx;
  logic         key_valid;
  logic         busy;
  logic         done;

  modport master (
    output start, key_in, out_ready,
    input  key_out, round_idx, key_valid, busy, done
  );

  modport slave (
    input  start, key_in, out_ready,
    output key_out, round_idx, key_valid, busy, done
  );
endinterface

// File: rtl/aes_key_unroll_128.sv
// aes_key_unroll_128
//   Sequential inverse key scheduler for AES-128 decryption. Loads the round-10
//   key and walks the schedule backwards one round per accepted beat,
//   presenting round keys 10..0 on a valid/ready stream.
//   clk - rising-edge clock
//   rst - synchronous, active-high reset
//   bus - aes_key_unroll_128_if.slave (start/key_in in, key stream out)
module aes_key_unroll_128 (
  input  logic                       clk,
  input  logic                       rst,
  aes_key_unroll_128_if.slave        bus
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]   state_q, state_d;
  logic [127:0] key_q, key_d;
  logic [3:0]   round_q, round_d;
  logic         done_q, done_d;

  logic [31:0]  a_s, b_s, c_s, d_s;
  logic [31:0]  a_n_s, b_n_s, c_n_s, d_n_s;
  logic [31:0]  rot_s, sub_s;
  logic [127:0] prev_key_s;

  // GF(2^8) multiply modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p;
    logic [7:0] xx;
    p  = 8'h00;
    xx = x;
    for (int i = 0; i < 8; i++) begin
      if (y[i]) begin
        p = p ^ xx;
      end else begin
        p = p;
      end
      xx = {xx[6:0], 1'b0} ^ (xx[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Forward S-box: multiplicative inverse (x^254, 0 maps to 0) then affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = x;
    inv = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
               ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  // Round constant of the round being left; anything outside 1..10 gives 00.
  function automatic logic [7:0] rcon(input logic [3:0] r);
    logic [7:0] v;
    case (r)
      4'd1:    v = 8'h01;
      4'd2:    v = 8'h02;
      4'd3:    v = 8'h04;
      4'd4:    v = 8'h08;
      4'd5:    v = 8'h10;
      4'd6:    v = 8'h20;
      4'd7:    v = 8'h40;
      4'd8:    v = 8'h80;
      4'd9:    v = 8'h1b;
      4'd10:   v = 8'h36;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  // One backward round step. d' feeds the S-box so the chain is XOR, S-box, XOR.
  always_comb begin
    a_s   = key_q[127:96];
    b_s   = key_q[95:64];
    c_s   = key_q[63:32];
    d_s   = key_q[31:0];
    d_n_s = d_s ^ c_s;
    c_n_s = c_s ^ b_s;
    b_n_s = b_s ^ a_s;
    rot_s = {d_n_s[23:0], d_n_s[31:24]};
    sub_s = {sbox(rot_s[31:24]), sbox(rot_s[23:16]), sbox(rot_s[15:8]), sbox(rot_s[7:0])};
    a_n_s = a_s ^ sub_s ^ {rcon(round_q), 24'h000000};
    prev_key_s = {a_n_s, b_n_s, c_n_s, d_n_s};
  end

  // Next-state logic: load in IDLE, step on each accepted beat in RUN.
  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    round_d = round_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          key_d   = bus.key_in;
          round_d = 4'd10;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (bus.out_ready) begin
          if (round_q == 4'd0) begin
            // Round 0 stays on key_out until the next load.
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            key_d   = prev_key_s;
            round_d = round_q - 4'd1;
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      key_q   <= 128'h0;
      round_q <= 4'h0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      round_q <= round_d;
      done_q  <= done_d;
    end
  end

  assign bus.key_out   = key_q;
  assign bus.round_idx = round_q;
  assign bus.key_valid = (state_q == ST_RUN);
  assign bus.busy      = (state_q == ST_RUN);
  assign bus.done      = done_q;

endmodule

// File: tb/tb_aes_key_unroll_128.sv
// tb_aes_key_unroll_128
//   Randomized bench for the inverse key scheduler. The reference forward-expands
//   random round-0 keys (log/antilog S-box), feeds round 10 in and expects the
//   forward keys back in reverse order, honouring stalls, resets and ignored starts.
module tb_aes_key_unroll_128;

  logic clk;
  logic rst;
  aes_key_unroll_128_if bus_if ();

  aes_key_unroll_128 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  int           gexp [0:255];
  int           glog [0:255];
  logic [7:0]   rc_tab [1:10];
  logic [127:0] next_keys [0:10];

  // Model state
  logic         model_on = 1'b0;
  logic         fips_on  = 1'b0;
  logic         m_run;
  logic [3:0]   m_round;
  logic [127:0] m_key;
  logic         m_done;
  logic [127:0] m_tab [0:10];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] xtime(input logic [7:0] v);
    return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] sbox_ref(input logic [7:0] x);
    logic [7:0] inv;
    logic [7:0] c;
    logic [7:0] s;
    c = 8'h63;
    if (x == 8'h00) inv = 8'h00;
    else inv = 8'(gexp[(255 - glog[x]) % 255]);
    for (int i = 0; i < 8; i++)
      s[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8] ^ inv[(i + 6) % 8] ^ inv[(i + 7) % 8] ^ c[i];
    return s;
  endfunction

  // Standard forward key expansion of k0 into next_keys[0..10].
  task automatic expand_into_next(input logic [127:0] k0);
    logic [31:0] w [0:43];
    logic [31:0] t;
    for (int i = 0; i < 4; i++) w[i] = k0[127 - 32 * i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i - 1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_ref(t[31:24]), sbox_ref(t[23:16]), sbox_ref(t[15:8]), sbox_ref(t[7:0])};
        t = t ^ {rc_tab[i / 4], 24'h000000};
      end
      w[i] = w[i - 4] ^ t;
    end
    for (int r = 0; r <= 10; r++) next_keys[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
  endtask

  // Reference behaviour: keys come from the forward table, indexed by round.
  always @(posedge clk) begin
    if (rst) begin
      m_run <= 1'b0; m_round <= 4'd0; m_key <= 128'h0; m_done <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (!m_run) begin
        if (bus_if.start) begin
          m_run <= 1'b1; m_round <= 4'd10; m_key <= bus_if.key_in;
          for (int i = 0; i <= 10; i++) m_tab[i] <= next_keys[i];
        end
      end else if (bus_if.out_ready) begin
        if (m_round == 4'd0) begin
          m_run <= 1'b0; m_done <= 1'b1;
        end else begin
          m_round <= m_round - 4'd1;
          m_key   <= m_tab[int'(m_round) - 1];
        end
      end
    end
  end

  // Compare process on the falling edge.
  always @(negedge clk) begin
    if (model_on) begin
      chk("busy",      {127'h0, bus_if.busy},      {127'h0, m_run});
      chk("key_valid", {127'h0, bus_if.key_valid}, {127'h0, m_run});
      chk("done",      {127'h0, bus_if.done},      {127'h0, m_done});
      chk("round_idx", {124'h0, bus_if.round_idx}, {124'h0, m_round});
      chk("key_out",   bus_if.key_out,             m_key);
      if (fips_on && bus_if.key_valid) begin
        case (bus_if.round_idx)
          4'd10: chk("fips_r10", bus_if.key_out, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
          4'd9:  chk("fips_r9",  bus_if.key_out, 128'hac7766f319fadc2128d12941575c006e);
          4'd1:  chk("fips_r1",  bus_if.key_out, 128'ha0fafe1788542cb123a339392a6c7605);
          4'd0:  chk("fips_r0",  bus_if.key_out, 128'h2b7e151628aed2a6abf7158809cf4f3c);
          default: ;
        endcase
      end
    end
  end

  task automatic begin_walk(input logic [127:0] k0);
    expand_into_next(k0);
    bus_if.start  = 1'b1;
    bus_if.key_in = next_keys[10];
    @(posedge clk); #1;
    bus_if.start  = 1'b0;
  endtask

  // Run until done with random stalls; optionally poke start at one round.
  task automatic drain(input int stall_pct, input int poke_round, output int cycles);
    bit poked;
    bit ok;
    poked  = 1'b0;
    ok     = 1'b0;
    cycles = 0;
    for (int k = 0; k < 400; k++) begin
      bus_if.start     = 1'b0;
      bus_if.out_ready = ($urandom_range(99) >= stall_pct);
      if (!poked && bus_if.key_valid && int'(bus_if.round_idx) == poke_round) begin
        bus_if.start  = 1'b1;
        bus_if.key_in = {$urandom, $urandom, $urandom, $urandom};
        poked = 1'b1;
      end
      @(posedge clk); #1;
      if (bus_if.done) begin
        ok = 1'b1;
        cycles = k + 2;
        break;
      end
    end
    bus_if.start = 1'b0;
    if (!ok) chk("drain_timeout", 128'd0, 128'd1);
  endtask

  initial begin
    int cyc;
    int v;
    logic [127:0] k;
    logic [127:0] fips_k0;

    // Log/antilog tables for generator 3, and round constants.
    v = 1;
    for (int i = 0; i < 255; i++) begin
      gexp[i] = v;
      glog[v] = i;
      v = int'(8'(v) ^ xtime(8'(v)));
    end
    gexp[255] = 1;
    glog[0] = 0;
    v = 1;
    for (int i = 1; i <= 10; i++) begin
      rc_tab[i] = 8'(v);
      v = int'(xtime(8'(v)));
    end

    // Pin the reference model with FIPS-197 literals.
    fips_k0 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    chk("model_sbox53", {120'h0, sbox_ref(8'h53)}, {120'h0, 8'hed});
    chk("model_sbox00", {120'h0, sbox_ref(8'h00)}, {120'h0, 8'h63});
    expand_into_next(fips_k0);
    chk("model_r10", next_keys[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    chk("model_r9",  next_keys[9],  128'hac7766f319fadc2128d12941575c006e);
    chk("model_r1",  next_keys[1],  128'ha0fafe1788542cb123a339392a6c7605);

    bus_if.start = 1'b0; bus_if.key_in = 128'h0; bus_if.out_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    model_on = 1'b1;
    rst = 1'b0;
    chk("reset_key",   bus_if.key_out, 128'h0);
    chk("reset_valid", {127'h0, bus_if.key_valid}, 128'h0);

    // FIPS walk with out_ready held high: done in cycle 12.
    fips_on = 1'b1;
    bus_if.out_ready = 1'b1;
    begin_walk(fips_k0);
    drain(0, 15, cyc);
    chk("fips_done_cycle", 128'(cyc), 128'd12);

    // Same vector under random backpressure, then with an ignored start at round 5.
    begin_walk(fips_k0);
    drain(40, 15, cyc);
    begin_walk(fips_k0);
    drain(20, 5, cyc);
    chk("ignored_start_r0", bus_if.key_out, 128'h2b7e151628aed2a6abf7158809cf4f3c);
    fips_on = 1'b0;

    // Back-to-back: start in the done cycle, round 10 appears next cycle.
    k = {$urandom, $urandom, $urandom, $urandom};
    begin_walk(k);
    chk("b2b_round", {124'h0, bus_if.round_idx}, 128'd10);
    chk("b2b_key",   bus_if.key_out, next_keys[10]);
    drain(0, 15, cyc);
    chk("b2b_done_cycle", 128'(cyc), 128'd12);

    // Reset at round 4, with a concurrent start that must be dropped.
    begin_walk({$urandom, $urandom, $urandom, $urandom});
    bus_if.out_ready = 1'b1;
    for (int i = 0; i < 30 && bus_if.round_idx != 4'd4; i++) begin
      @(posedge clk); #1;
    end
    chk("reach_round4", {124'h0, bus_if.round_idx}, 128'd4);
    rst = 1'b1;
    bus_if.start  = 1'b1;
    bus_if.key_in = {$urandom, $urandom, $urandom, $urandom};
    @(posedge clk); #1;
    rst = 1'b0;
    bus_if.start = 1'b0;
    chk("rst_key",   bus_if.key_out, 128'h0);
    chk("rst_round", {124'h0, bus_if.round_idx}, 128'd0);
    chk("rst_valid", {127'h0, bus_if.key_valid}, 128'd0);
    chk("rst_busy",  {127'h0, bus_if.busy}, 128'd0);
    chk("rst_done",  {127'h0, bus_if.done}, 128'd0);
    @(posedge clk); #1;
    chk("rst_start_dropped", {127'h0, bus_if.busy}, 128'd0);
    begin_walk({$urandom, $urandom, $urandom, $urandom});
    drain(25, 15, cyc);

    // Round trip on 200 random keys, chained back to back.
    for (int i = 0; i < 200; i++) begin
      begin_walk({$urandom, $urandom, $urandom, $urandom});
      drain((i % 2 == 1) ? 30 : 0, 15, cyc);
    end

    repeat (3) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
